// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared state type, default geometry and width helper for the HUB75 shifter
package hub75_pkg;

    localparam int HUB75_COLS     = 64;
    localparam int HUB75_CHANNELS = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } hub75_state_t;

    // Counter width for a count of n items; never narrower than one bit.
    function automatic int hub75_col_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hub75_shift_lane.sv
// rtl/hub75_shift_lane.sv - one serial lane: parallel load, single-bit advance, registered output bit
module hub75_shift_lane #(
    parameter int COLS      = 64,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic            shift_en,
    input  logic [COLS-1:0] load_data,
    output logic            bit_out
);

    // active holds the bits still queued behind bit_out, already advanced by one.
    logic [COLS-1:0] active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active  <= '0;
            bit_out <= 1'b0;
        end else if (load_en) begin
            if (MSB_FIRST) begin
                bit_out <= load_data[COLS-1];
                active  <= load_data << 1;
            end else begin
                bit_out <= load_data[0];
                active  <= load_data >> 1;
            end
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                bit_out <= active[COLS-1];
                active  <= active << 1;
            end else begin
                bit_out <= active[0];
                active  <= active >> 1;
            end
        end
    end

endmodule

// File: rtl/hub75_channel_shifter.sv
// rtl/hub75_channel_shifter.sv - double-buffered multi-lane HUB75 row serialiser with shift clock and latch
module hub75_channel_shifter
    import hub75_pkg::*;
#(
    parameter int COLS       = HUB75_COLS,
    parameter int CHANNELS   = HUB75_CHANNELS,
    parameter int LAT_CYCLES = 2,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [CHANNELS*COLS-1:0] load_data,
    output logic                     load_ready,
    output logic [CHANNELS-1:0]      out_data,
    output logic                     out_sclk,
    output logic                     out_lat,
    output logic                     busy,
    output logic                     row_done
);

    localparam int COL_W = hub75_col_w(COLS);
    localparam int LAT_W = hub75_col_w(LAT_CYCLES);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(LAT_CYCLES - 1);

    hub75_state_t               state;
    logic [COL_W-1:0]           col_cnt;
    logic [LAT_W-1:0]           lat_cnt;
    logic [CHANNELS*COLS-1:0]   shadow;
    logic                       shadow_full;
    logic                       xfer;
    logic                       lane_shift;

    assign load_ready = !shadow_full;
    assign busy       = (state != IDLE);
    assign xfer       = (state == IDLE) && shadow_full;
    // The last column keeps its bit on the lines through the latch.
    assign lane_shift = (state == SHIFT_HI) && (col_cnt != LAST_COL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow      <= '0;
            shadow_full <= 1'b0;
        end else if (load && load_ready) begin
            shadow      <= load_data;
            shadow_full <= 1'b1;
        end else if (xfer) begin
            shadow_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            col_cnt  <= '0;
            lat_cnt  <= '0;
            out_sclk <= 1'b0;
            out_lat  <= 1'b0;
            row_done <= 1'b0;
        end else begin
            row_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (shadow_full) begin
                        col_cnt <= '0;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    out_sclk <= 1'b1;
                    state    <= SHIFT_HI;
                end
                SHIFT_HI: begin
                    out_sclk <= 1'b0;
                    if (col_cnt == LAST_COL) begin
                        out_lat <= 1'b1;
                        lat_cnt <= '0;
                        state   <= LATCH;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                        state   <= SHIFT_LO;
                    end
                end
                LATCH: begin
                    if (lat_cnt == LAST_LAT) begin
                        out_lat  <= 1'b0;
                        row_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        hub75_shift_lane #(
            .COLS      (COLS),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load_en   (xfer),
            .shift_en  (lane_shift),
            .load_data (shadow[c*COLS +: COLS]),
            .bit_out   (out_data[c])
        );
    end

endmodule

// File: tb/tb_hub75_channel_shifter.sv
// tb/tb_hub75_channel_shifter.sv - self-checking bench for hub75_channel_shifter
module tb_hub75_channel_shifter;

    localparam int COLS  = 64;
    localparam int CH    = 6;
    localparam int LAT   = 2;
    localparam int ROWW  = CH * COLS;
    localparam int C8    = 8;
    localparam int LAT8  = 3;
    localparam int ROWW8 = CH * C8;
    localparam int PERIOD = 2 * COLS + LAT + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            load = 1'b0;
    logic [ROWW-1:0] load_data = '0;
    logic            load_ready;
    logic [CH-1:0]   out_data;
    logic            out_sclk, out_lat, busy, row_done;

    logic             load8 = 1'b0;
    logic [ROWW8-1:0] load_data8 = '0;
    logic             load_ready8;
    logic [CH-1:0]    out_data8;
    logic             out_sclk8, out_lat8, busy8, row_done8;

    hub75_channel_shifter #(.COLS(COLS), .CHANNELS(CH), .LAT_CYCLES(LAT), .MSB_FIRST(1'b0)) u_dut (
        .clk(clk), .rst(rst), .load(load), .load_data(load_data), .load_ready(load_ready),
        .out_data(out_data), .out_sclk(out_sclk), .out_lat(out_lat), .busy(busy), .row_done(row_done)
    );

    hub75_channel_shifter #(.COLS(C8), .CHANNELS(CH), .LAT_CYCLES(LAT8), .MSB_FIRST(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .load(load8), .load_data(load_data8), .load_ready(load_ready8),
        .out_data(out_data8), .out_sclk(out_sclk8), .out_lat(out_lat8), .busy(busy8), .row_done(row_done8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [ROWW-1:0] obs, input logic [ROWW-1:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reconstructs each row from the serial stream of the default instance.
    logic [ROWW-1:0] rec = '0;
    int              k_rise = 0;
    logic            prev_sclk = 1'b0, prev_lat = 1'b0;
    logic [CH-1:0]   prev_data = '0;
    int              lat_len = 0;
    int              overlap_err = 0, setup_err = 0;
    logic [ROWW-1:0] got_rows[$];
    int              got_rises[$];
    int              lat_edges[$];
    int              lat_lens[$];
    int              rd_edges[$];

    always @(negedge clk) begin
        if (!rst) begin
            rec = '0; k_rise = 0; prev_sclk = 1'b0; prev_lat = 1'b0; prev_data = '0; lat_len = 0;
        end else begin
            if (out_sclk && !prev_sclk) begin
                if (out_data !== prev_data) setup_err++;
                if (k_rise < COLS)
                    for (int c = 0; c < CH; c++) rec[c*COLS + k_rise] = out_data[c];
                k_rise++;
            end
            if (out_sclk && out_lat) overlap_err++;
            if (out_lat && !prev_lat) begin
                got_rows.push_back(rec);
                got_rises.push_back(k_rise);
                lat_edges.push_back(cyc - 1);
                rec = '0; k_rise = 0; lat_len = 1;
            end else if (out_lat) begin
                lat_len++;
            end
            if (!out_lat && prev_lat) lat_lens.push_back(lat_len);
            if (row_done) rd_edges.push_back(cyc - 1);
            prev_sclk = out_sclk; prev_lat = out_lat; prev_data = out_data;
        end
    end

    function automatic logic [ROWW-1:0] rand_row();
        logic [ROWW-1:0] r;
        for (int i = 0; i < ROWW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic load_row(input logic [ROWW-1:0] d, output int acc);
        int t = 0;
        @(negedge clk); #1;
        while (!load_ready && t < 1000) begin @(negedge clk); #1; t++; end
        check("load_ready before load", load_ready, 1);
        load = 1'b1; load_data = d;
        @(posedge clk); acc = cyc;
        #1 load = 1'b0;
    endtask

    task automatic wait_rows(input int n, input int budget);
        int t = 0;
        while (rd_edges.size() < n && t < budget) begin @(negedge clk); #1; t++; end
        check("row_done count reached", (rd_edges.size() >= n), 1);
    endtask

    task automatic run8(input logic [ROWW8-1:0] d, input string tag);
        logic [ROWW8-1:0] r8 = '0;
        int k = 0, latn = 0, t = 0, acc = 0, rd = -1, late = -1;
        logic ps = 1'b0;
        @(negedge clk); #1;
        load8 = 1'b1; load_data8 = d;
        @(posedge clk); acc = cyc;
        #1 load8 = 1'b0;
        while (rd < 0 && t < 200) begin
            @(negedge clk); #1; t++;
            if (out_sclk8 && !ps) begin
                if (k < C8)
                    for (int c = 0; c < CH; c++) r8[c*C8 + (C8 - 1 - k)] = out_data8[c];
                k++;
            end
            if (out_lat8) begin
                if (late < 0) late = cyc - 1;
                latn++;
            end
            if (out_lat8 && out_sclk8) latn = -100;
            if (row_done8) rd = cyc - 1;
            ps = out_sclk8;
        end
        check({tag, " data"}, r8, d);
        check({tag, " rises"}, k, C8);
        check({tag, " lat width"}, latn, LAT8);
        check({tag, " lat edge"}, late, acc + 2*C8 + 1);
        check({tag, " row_done edge"}, rd, acc + 2*C8 + 1 + LAT8);
    endtask

    initial begin
        logic [ROWW-1:0]  ra, rb, rc, rf;
        logic [ROWW8-1:0] d8;
        int acc_a, acc_b, acc_c, i0, r0, t;

        // Reset held with load asserted
        rst = 1'b0; load = 1'b1; load_data = {12{32'hDEADBEEF}}; load8 = 1'b1; load_data8 = '1;
        repeat (3) @(negedge clk);
        #1;
        check("rst out_data", out_data, 0);
        check("rst out_sclk", out_sclk, 0);
        check("rst out_lat", out_lat, 0);
        check("rst busy", busy, 0);
        check("rst row_done", row_done, 0);
        check("rst load_ready", load_ready, 1);
        check("rst out_data8", out_data8, 0);
        load = 1'b0; load8 = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("post-rst idle", busy, 0);
        check("post-rst load_ready", load_ready, 1);

        // Single row, LSB first, fixed pattern on lane 0
        ra = '0; ra[63:0] = 64'h391EABCE0AB8DE7F;
        load_row(ra, acc_a);
        wait_rows(1, 400);
        check("single data", got_rows[0], ra);
        check("single rises", got_rises[0], COLS);
        check("single lat edge", lat_edges[0], acc_a + 2*COLS + 1);
        check("single lat width", lat_lens[0], LAT);
        check("single row_done edge", rd_edges[0], acc_a + 2*COLS + 1 + LAT);

        // MSB first, 8 columns, lane 3 = A5, then a random row
        d8 = '0; d8[3*C8 +: C8] = 8'hA5;
        run8(d8, "msb A5");
        for (int i = 0; i < ROWW8 / 16; i++) d8[i*16 +: 16] = 16'($urandom);
        run8(d8, "msb rand");

        // Back-to-back streaming of three random rows
        i0 = got_rows.size(); r0 = rd_edges.size();
        ra = rand_row(); rb = rand_row(); rc = rand_row();
        load_row(ra, acc_a);
        repeat (10) @(negedge clk);
        load_row(rb, acc_b);
        @(negedge clk); #1;
        check("C refused while B shadowed", load_ready, 0);
        load_row(rc, acc_c);
        check("C accepted after B transfer", acc_c, acc_a + 2*COLS + LAT + 3);
        wait_rows(r0 + 3, 800);
        check("b2b row A", got_rows[i0], ra);
        check("b2b row B", got_rows[i0+1], rb);
        check("b2b row C", got_rows[i0+2], rc);
        check("b2b A lat edge", lat_edges[i0], acc_a + 2*COLS + 1);
        check("b2b A-B spacing", lat_edges[i0+1] - lat_edges[i0], PERIOD);
        check("b2b B-C spacing", lat_edges[i0+2] - lat_edges[i0+1], PERIOD);
        repeat (20) @(negedge clk);
        #1;
        check("b2b no extra row", got_rows.size(), i0 + 3);
        check("b2b idle", busy, 0);

        // Load pulsed while shadow full is ignored
        i0 = got_rows.size(); r0 = rd_edges.size();
        ra = rand_row(); rb = rand_row(); rf = ~rb;
        load_row(ra, acc_a);
        load_row(rb, acc_b);
        @(negedge clk); #1;
        check("shadow full ready", load_ready, 0);
        load = 1'b1; load_data = rf;
        @(posedge clk); #1 load = 1'b0;
        wait_rows(r0 + 2, 600);
        check("ignored: row A", got_rows[i0], ra);
        check("ignored: shadow kept B", got_rows[i0+1], rb);
        repeat (20) @(negedge clk);
        #1;
        check("ignored: no extra row", got_rows.size(), i0 + 2);

        // Reset in the middle of a row with the shadow full
        i0 = got_rows.size(); r0 = rd_edges.size();
        ra = rand_row(); rb = rand_row();
        load_row(ra, acc_a);
        load_row(rb, acc_b);
        t = 0;
        while (!(k_rise == 21 && out_sclk) && t < 200) begin @(negedge clk); #1; t++; end
        check("reached column 20", k_rise, 21);
        #2 rst = 1'b0;
        #1;
        check("mid-rst out_sclk", out_sclk, 0);
        check("mid-rst out_lat", out_lat, 0);
        check("mid-rst out_data", out_data, 0);
        check("mid-rst busy", busy, 0);
        check("mid-rst load_ready", load_ready, 1);
        @(negedge clk); #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("shadow discarded", busy, 0);
        check("no partial row", got_rows.size(), i0);
        rc = rand_row();
        load_row(rc, acc_c);
        wait_rows(r0 + 1, 400);
        check("after rst data", got_rows[i0], rc);
        check("after rst rises", got_rises[i0], COLS);
        check("after rst lat edge", lat_edges[i0], acc_c + 2*COLS + 1);

        check("sclk/lat overlap", overlap_err, 0);
        check("data setup before rise", setup_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
